// File: rtl/mips_pkg.sv
// Shared MIPS register-file constants and the link-address helper.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package mips_pkg;

  localparam int REG_ZERO         = 0;   // hardwired-zero register
  localparam int REG_RA           = 31;  // return-address register written by JAL
  localparam int DEFAULT_DW       = 32;
  localparam int DEFAULT_NUM_REGS = 32;
  // Widest datapath the link helper supports; narrower callers truncate.
  localparam int MAX_DW           = 64;

  // Return address of a linking instruction. Wraps modulo 2^width.
  function automatic logic [MAX_DW-1:0] link_addr(input logic [MAX_DW-1:0] pc);
    return pc + 64'd4;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One register-file read port: array lookup, write-through bypass, busy qualification.
// Latency: 0 cycles (purely combinational).
// Backpressure: none; always produces data for the presented address.
//  i_addr              register index to read
//  i_regs / i_busy     flattened stored values and pending-load bits from the top
//  i_wr_* / i_lk_*     this cycle's qualified data and link writes (for bypass)
//  o_data / o_busy     read value and "pending load, not being written now" flag
module regfile_read_port
  import mips_pkg::*;
#(
  parameter  int DW       = DEFAULT_DW,
  parameter  int NUM_REGS = DEFAULT_NUM_REGS,
  parameter  int LINK_REG = REG_RA,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic [AW-1:0]          i_addr,
  input  logic [NUM_REGS*DW-1:0] i_regs,
  input  logic [NUM_REGS-1:0]    i_busy,
  input  logic                   i_wr_en,
  input  logic [AW-1:0]          i_wr_addr,
  input  logic [DW-1:0]          i_wr_data,
  input  logic                   i_lk_en,
  input  logic [DW-1:0]          i_lk_data,
  output logic [DW-1:0]          o_data,
  output logic                   o_busy
);

  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

  logic          w_lk_hit;
  logic          w_wr_hit;
  logic [DW-1:0] w_stored;

  // Enables arrive already qualified (reset, register 0), so a hit is a real write.
  assign w_lk_hit = i_lk_en && (i_addr == LINK_A);
  assign w_wr_hit = i_wr_en && (i_addr == i_wr_addr);
  assign w_stored = i_regs[int'(i_addr)*DW +: DW];

  // Link has priority over the data write, matching the array update.
  assign o_data = w_lk_hit ? i_lk_data :
                  w_wr_hit ? i_wr_data : w_stored;

  // A value being written this cycle is bypassed, so it is not stale.
  assign o_busy = i_busy[i_addr] && !(w_lk_hit || w_wr_hit);

endmodule

// File: rtl/regfile_scoreboard.sv
// MIPS GPR file with NUM_RD read ports, data + link write ports and a load scoreboard.
// Latency: reads 0 cycles with write-through bypass; writes and busy updates at posedge.
// Backpressure: none; RdBusy tells the hazard unit when a register awaits a load.
//  CLK, RST_N                  clock, async active-low reset
//  RdAddr/RdData/RdBusy        packed read ports, port k at [k*AW], [k*DW], [k]
//  WrEn/WrAddr/WrData          data write port
//  LinkEn/LinkPC               link write, stores LinkPC+4 into LINK_REG
//  BusySet/BusySetAddr         mark a register as awaiting a load
module regfile_scoreboard
  import mips_pkg::*;
#(
  parameter  int DW       = DEFAULT_DW,
  parameter  int NUM_REGS = DEFAULT_NUM_REGS,
  parameter  int NUM_RD   = 2,
  parameter  int LINK_REG = REG_RA,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NUM_RD*AW-1:0] RdAddr,
  output logic [NUM_RD*DW-1:0] RdData,
  output logic [NUM_RD-1:0]    RdBusy,
  input  logic                 WrEn,
  input  logic [AW-1:0]        WrAddr,
  input  logic [DW-1:0]        WrData,
  input  logic                 LinkEn,
  input  logic [DW-1:0]        LinkPC,
  input  logic                 BusySet,
  input  logic [AW-1:0]        BusySetAddr
);

  localparam logic [AW-1:0] ZERO_A = AW'(REG_ZERO);
  localparam logic [AW-1:0] LINK_A = AW'(LINK_REG);

  logic [DW-1:0]          r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]    r_busy;

  logic                   w_wr_en;
  logic                   w_lk_en;
  logic [DW-1:0]          w_lk_data;
  logic [NUM_REGS*DW-1:0] w_regs_flat;

  // Qualified enables: writes to $0 vanish, and nothing bypasses while in reset
  // so the read ports show zero for the whole reset window.
  assign w_wr_en   = RST_N && WrEn && (WrAddr != ZERO_A);
  assign w_lk_en   = RST_N && LinkEn && (LINK_A != ZERO_A);
  assign w_lk_data = DW'(link_addr(MAX_DW'(LinkPC)));

  always_comb begin
    w_regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_regs_flat[i*DW +: DW] = r_regs[i];
    end
  end

  // Entry 0 is only ever written by reset, which keeps $0 and its busy bit at zero.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
      r_busy <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (w_lk_en && (LINK_A == AW'(i))) begin
          r_regs[i] <= w_lk_data;
        end else if (w_wr_en && (WrAddr == AW'(i))) begin
          r_regs[i] <= WrData;
        end
        // A load issued this cycle is newer than the write retiring, so set wins.
        if (BusySet && (BusySetAddr == AW'(i))) begin
          r_busy[i] <= 1'b1;
        end else if ((w_lk_en && (LINK_A == AW'(i))) ||
                     (w_wr_en && (WrAddr == AW'(i)))) begin
          r_busy[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    regfile_read_port #(
      .DW       (DW),
      .NUM_REGS (NUM_REGS),
      .LINK_REG (LINK_REG)
    ) u_rd (
      .i_addr    (RdAddr[k*AW +: AW]),
      .i_regs    (w_regs_flat),
      .i_busy    (r_busy),
      .i_wr_en   (w_wr_en),
      .i_wr_addr (WrAddr),
      .i_wr_data (WrData),
      .i_lk_en   (w_lk_en),
      .i_lk_data (w_lk_data),
      .o_data    (RdData[k*DW +: DW]),
      .o_busy    (RdBusy[k])
    );
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: default 32x32/2-port instance (a_*) and a
// 64-bit 16-entry 4-port instance with link register 15 (b_*).
module tb_regfile_scoreboard;

  logic CLK = 1'b0;
  logic RST_N;
  always #5 CLK = ~CLK;

  // Instance A: DW=32, NUM_REGS=32, NUM_RD=2, LINK_REG=31
  logic [9:0]  a_rd_addr;
  logic [63:0] a_rd_data;
  logic [1:0]  a_rd_busy;
  logic        a_wr_en;
  logic [4:0]  a_wr_addr;
  logic [31:0] a_wr_data;
  logic        a_lk_en;
  logic [31:0] a_lk_pc;
  logic        a_bs;
  logic [4:0]  a_bs_addr;

  // Instance B: DW=64, NUM_REGS=16, NUM_RD=4, LINK_REG=15
  logic [15:0]  b_rd_addr;
  logic [255:0] b_rd_data;
  logic [3:0]   b_rd_busy;
  logic         b_wr_en;
  logic [3:0]   b_wr_addr;
  logic [63:0]  b_wr_data;
  logic         b_lk_en;
  logic [63:0]  b_lk_pc;
  logic         b_bs;
  logic [3:0]   b_bs_addr;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_scoreboard u_dut_a (
    .CLK(CLK), .RST_N(RST_N),
    .RdAddr(a_rd_addr), .RdData(a_rd_data), .RdBusy(a_rd_busy),
    .WrEn(a_wr_en), .WrAddr(a_wr_addr), .WrData(a_wr_data),
    .LinkEn(a_lk_en), .LinkPC(a_lk_pc),
    .BusySet(a_bs), .BusySetAddr(a_bs_addr)
  );

  regfile_scoreboard #(.DW(64), .NUM_REGS(16), .NUM_RD(4), .LINK_REG(15)) u_dut_b (
    .CLK(CLK), .RST_N(RST_N),
    .RdAddr(b_rd_addr), .RdData(b_rd_data), .RdBusy(b_rd_busy),
    .WrEn(b_wr_en), .WrAddr(b_wr_addr), .WrData(b_wr_data),
    .LinkEn(b_lk_en), .LinkPC(b_lk_pc),
    .BusySet(b_bs), .BusySetAddr(b_bs_addr)
  );

  task automatic idle_a();
    a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
    a_lk_en = 1'b0; a_lk_pc = '0; a_bs = 1'b0; a_bs_addr = '0;
  endtask

  task automatic idle_b();
    b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
    b_lk_en = 1'b0; b_lk_pc = '0; b_bs = 1'b0; b_bs_addr = '0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; idle_a(); idle_b();
    a_rd_addr = {5'd7, 5'd5}; b_rd_addr = '0;
    @(negedge CLK); @(negedge CLK);
    n_tests++;
    if (a_rd_data !== 64'h0 || a_rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL reset_state got data=%h busy=%b want 0/00", a_rd_data, a_rd_busy);
    end
    RST_N = 1'b1;
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hA5A5A5A5;
    a_bs = 1'b1; a_bs_addr = 5'd7;
    @(negedge CLK); idle_a(); #1;
    n_tests++;
    if (a_rd_data[31:0] !== 32'hA5A5A5A5 || a_rd_busy !== 2'b10) begin
      n_fail++; $display("FAIL reset_preload got data=%h busy=%b want a5a5a5a5/10", a_rd_data[31:0], a_rd_busy);
    end
    #2 RST_N = 1'b0; #1;
    n_tests++;
    if (a_rd_data !== 64'h0 || a_rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL reset_async got data=%h busy=%b want 0/00", a_rd_data, a_rd_busy);
    end
    @(negedge CLK); RST_N = 1'b1; #1;
    n_tests++;
    if (a_rd_data !== 64'h0 || a_rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL reset_release got data=%h busy=%b want 0/00", a_rd_data, a_rd_busy);
    end
  endtask

  task automatic test_write_read();
    @(negedge CLK);
    a_rd_addr = {5'd5, 5'd5};
    a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF; #1;
    n_tests++;
    if (a_rd_data !== 64'hDEADBEEF_DEADBEEF) begin
      n_fail++; $display("FAIL wr_bypass got %h want deadbeefdeadbeef", a_rd_data);
    end
    @(negedge CLK); idle_a(); #1;
    n_tests++;
    if (a_rd_data !== 64'hDEADBEEF_DEADBEEF) begin
      n_fail++; $display("FAIL wr_stored got %h want deadbeefdeadbeef", a_rd_data);
    end
    a_rd_addr = {5'd5, 5'd0};
    a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'h1234; #1;
    n_tests++;
    if (a_rd_data !== 64'hDEADBEEF_00000000) begin
      n_fail++; $display("FAIL zero_bypass got %h want deadbeef00000000", a_rd_data);
    end
    @(negedge CLK); idle_a(); #1;
    n_tests++;
    if (a_rd_data !== 64'hDEADBEEF_00000000) begin
      n_fail++; $display("FAIL zero_stored got %h want deadbeef00000000", a_rd_data);
    end
  endtask

  task automatic test_link();
    @(negedge CLK);
    a_rd_addr = {5'd5, 5'd31};
    a_wr_en = 1'b1; a_wr_addr = 5'd31; a_wr_data = 32'h11;
    a_lk_en = 1'b1; a_lk_pc = 32'h00400010; #1;
    n_tests++;
    if (a_rd_data !== 64'hDEADBEEF_00400014) begin
      n_fail++; $display("FAIL link_bypass got %h want deadbeef00400014", a_rd_data);
    end
    @(negedge CLK); idle_a(); #1;
    n_tests++;
    if (a_rd_data[31:0] !== 32'h00400014) begin
      n_fail++; $display("FAIL link_stored got %h want 00400014", a_rd_data[31:0]);
    end
    a_lk_en = 1'b1; a_lk_pc = 32'hFFFFFFFC; #1;
    n_tests++;
    if (a_rd_data[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL link_wrap_bypass got %h want 00000000", a_rd_data[31:0]);
    end
    @(negedge CLK); idle_a(); #1;
    n_tests++;
    if (a_rd_data[31:0] !== 32'h0) begin
      n_fail++; $display("FAIL link_wrap_stored got %h want 00000000", a_rd_data[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    @(negedge CLK);
    a_rd_addr = {5'd8, 5'd8};
    a_bs = 1'b1; a_bs_addr = 5'd8; #1;
    n_tests++;
    if (a_rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL busy_same_cycle got %b want 00", a_rd_busy);
    end
    @(negedge CLK); idle_a(); #1;
    n_tests++;
    if (a_rd_busy !== 2'b11) begin
      n_fail++; $display("FAIL busy_set got %b want 11", a_rd_busy);
    end
    a_wr_en = 1'b1; a_wr_addr = 5'd8; a_wr_data = 32'hCAFE; #1;
    n_tests++;
    if (a_rd_busy !== 2'b00 || a_rd_data !== 64'h0000CAFE_0000CAFE) begin
      n_fail++; $display("FAIL busy_bypass got busy=%b data=%h want 00/0000cafe0000cafe", a_rd_busy, a_rd_data);
    end
    @(negedge CLK); idle_a(); #1;
    n_tests++;
    if (a_rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL busy_cleared got %b want 00", a_rd_busy);
    end
    a_rd_addr = {5'd31, 5'd31};
    a_bs = 1'b1; a_bs_addr = 5'd31;
    @(negedge CLK); idle_a();
    a_lk_en = 1'b1; a_lk_pc = 32'h100; #1;
    n_tests++;
    if (a_rd_busy !== 2'b00 || a_rd_data[31:0] !== 32'h104) begin
      n_fail++; $display("FAIL busy_link_bypass got busy=%b data=%h want 00/00000104", a_rd_busy, a_rd_data[31:0]);
    end
    @(negedge CLK); idle_a(); #1;
    n_tests++;
    if (a_rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL busy_link_cleared got %b want 00", a_rd_busy);
    end
  endtask

  task automatic test_collision();
    @(negedge CLK);
    a_rd_addr = {5'd9, 5'd9};
    a_bs = 1'b1; a_bs_addr = 5'd9;
    a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h99;
    @(negedge CLK); idle_a(); #1;
    n_tests++;
    if (a_rd_busy !== 2'b11 || a_rd_data !== 64'h00000099_00000099) begin
      n_fail++; $display("FAIL collision got busy=%b data=%h want 11/0000009900000099", a_rd_busy, a_rd_data);
    end
    a_rd_addr = {5'd0, 5'd0};
    a_bs = 1'b1; a_bs_addr = 5'd0;
    @(negedge CLK); idle_a(); #1;
    n_tests++;
    if (a_rd_busy !== 2'b00) begin
      n_fail++; $display("FAIL busy_zero got %b want 00", a_rd_busy);
    end
    @(negedge CLK); #1;
    n_tests++;
    if (a_rd_busy !== 2'b00 || a_rd_data !== 64'h0) begin
      n_fail++; $display("FAIL busy_zero_later got busy=%b data=%h want 00/0", a_rd_busy, a_rd_data);
    end
  endtask

  task automatic test_param_sweep();
    logic [63:0] v;
    v = 64'hDEADBEEF_01234567;
    @(negedge CLK);
    b_rd_addr = {4'd0, 4'd3, 4'd5, 4'd5};
    b_wr_en = 1'b1; b_wr_addr = 4'd5; b_wr_data = v; #1;
    n_tests++;
    if (b_rd_data !== {64'h0, 64'h0, v, v}) begin
      n_fail++; $display("FAIL p_wr_bypass got %h", b_rd_data);
    end
    @(negedge CLK); idle_b(); #1;
    n_tests++;
    if (b_rd_data !== {64'h0, 64'h0, v, v}) begin
      n_fail++; $display("FAIL p_wr_stored got %h", b_rd_data);
    end
    b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = 64'h1234;
    @(negedge CLK); idle_b(); #1;
    n_tests++;
    if (b_rd_data[255:192] !== 64'h0) begin
      n_fail++; $display("FAIL p_zero got %h want 0", b_rd_data[255:192]);
    end
    b_rd_addr = {4'd15, 4'd5, 4'd15, 4'd15};
    b_wr_en = 1'b1; b_wr_addr = 4'd15; b_wr_data = 64'h11;
    b_lk_en = 1'b1; b_lk_pc = 64'h00400010; #1;
    n_tests++;
    if (b_rd_data !== {64'h00400014, v, 64'h00400014, 64'h00400014}) begin
      n_fail++; $display("FAIL p_link_bypass got %h", b_rd_data);
    end
    @(negedge CLK); idle_b();
    b_lk_en = 1'b1; b_lk_pc = 64'hFFFFFFFC;
    @(negedge CLK); idle_b(); #1;
    n_tests++;
    if (b_rd_data[63:0] !== 64'h1_00000000) begin
      n_fail++; $display("FAIL p_link_64 got %h want 0000000100000000", b_rd_data[63:0]);
    end
    b_lk_en = 1'b1; b_lk_pc = 64'hFFFFFFFF_FFFFFFFC;
    @(negedge CLK); idle_b(); #1;
    n_tests++;
    if (b_rd_data !== {64'h0, v, 64'h0, 64'h0}) begin
      n_fail++; $display("FAIL p_link_wrap got %h", b_rd_data);
    end
    b_rd_addr = {4'd2, 4'd8, 4'd8, 4'd8};
    b_bs = 1'b1; b_bs_addr = 4'd8;
    @(negedge CLK); idle_b(); #1;
    n_tests++;
    if (b_rd_busy !== 4'b0111) begin
      n_fail++; $display("FAIL p_busy_set got %b want 0111", b_rd_busy);
    end
    b_wr_en = 1'b1; b_wr_addr = 4'd8; b_wr_data = 64'hCAFE; #1;
    n_tests++;
    if (b_rd_busy !== 4'b0000 || b_rd_data !== {64'h0, 64'hCAFE, 64'hCAFE, 64'hCAFE}) begin
      n_fail++; $display("FAIL p_busy_bypass got busy=%b data=%h", b_rd_busy, b_rd_data);
    end
    @(negedge CLK); idle_b(); #1;
    n_tests++;
    if (b_rd_busy !== 4'b0000) begin
      n_fail++; $display("FAIL p_busy_cleared got %b want 0000", b_rd_busy);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_link();
    test_scoreboard();
    test_collision();
    test_param_sweep();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
